// File: rtl/grf_wb_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// grf_wb_arbiter_pkg : shared widths, FSM encodings and trace source tags
// Revision: 1.0
// ============================================================================
package grf_wb_arbiter_pkg;

  localparam int AW = 5;
  localparam int DW = 32;

  typedef enum logic [0:0] {
    ST_NORMAL = 1'b0,
    ST_FORCE  = 1'b1
  } state_t;

  typedef enum logic [0:0] {
    SRC_PIPE = 1'b0,
    SRC_AUX  = 1'b1
  } src_t;

  localparam logic [15:0] TAG_PIPE = " P";
  localparam logic [15:0] TAG_AUX  = " A";

endpackage
`default_nettype wire

// File: rtl/grf_wb_arbiter_fifo.sv
`default_nettype none
// ============================================================================
// grf_wb_fifo : DEPTH-entry synchronous FIFO for aux writes, with per-entry
//               valid/addr exposed for pending-write lookup
// Revision: 1.0
// ============================================================================
module grf_wb_fifo
  import grf_wb_arbiter_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [AW-1:0]            i_addr,
  input  logic [DW-1:0]            i_wd,
  input  logic [DW-1:0]            i_pc,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [AW-1:0]            o_head_addr,
  output logic [DW-1:0]            o_head_wd,
  output logic [DW-1:0]            o_head_pc,
  output logic [DEPTH-1:0]         o_vld,
  output logic [DEPTH-1:0][AW-1:0] o_ent_addr
);

  localparam int PW = $clog2(DEPTH);

  logic [PW-1:0]             r_wr;
  logic [PW-1:0]             r_rd;
  logic [PW:0]               r_count;
  logic [DEPTH-1:0]          r_vld;
  logic [DEPTH-1:0][AW-1:0]  r_addr;
  logic [DEPTH-1:0][DW-1:0]  r_wd;
  logic [DEPTH-1:0][DW-1:0]  r_pc;
  logic                      w_push;
  logic                      w_pop;

  assign o_full  = (r_count == (PW+1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;

  assign o_head_addr = r_addr[r_rd];
  assign o_head_wd   = r_wd[r_rd];
  assign o_head_pc   = r_pc[r_rd];
  assign o_vld       = r_vld;
  assign o_ent_addr  = r_addr;

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
      r_vld   <= '0;
    end else begin
      if (w_push) begin
        r_addr[r_wr] <= i_addr;
        r_wd[r_wr]   <= i_wd;
        r_pc[r_wr]   <= i_pc;
        r_vld[r_wr]  <= 1'b1;
        r_wr         <= r_wr + 1'b1;
      end
      if (w_pop) begin
        r_vld[r_rd] <= 1'b0;
        r_rd        <= r_rd + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/grf_wb_arbiter.sv
`default_nettype none
// ============================================================================
// grf_wb_arbiter : GRF write-port arbiter (pipe priority, aux FIFO, starvation
//                  stall). Optional trace print under GRF_WB_TRACE_EN.
// Revision: 1.0
// ============================================================================
module grf_wb_arbiter
  import grf_wb_arbiter_pkg::*;
#(
  parameter int DEPTH    = 2,
  parameter int MAX_WAIT = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_pipe_we,
  input  logic [AW-1:0] i_pipe_addr,
  input  logic [DW-1:0] i_pipe_wd,
  input  logic [DW-1:0] i_pipe_pc,
  output logic          o_pipe_stall,
  input  logic          i_aux_valid,
  output logic          o_aux_ready,
  input  logic [AW-1:0] i_aux_addr,
  input  logic [DW-1:0] i_aux_wd,
  input  logic [DW-1:0] i_aux_pc,
  input  logic [AW-1:0] i_pend_q1,
  input  logic [AW-1:0] i_pend_q2,
  output logic          o_pend_busy1,
  output logic          o_pend_busy2,
  output logic          o_grf_we,
  output logic [AW-1:0] o_grf_addr,
  output logic [DW-1:0] o_grf_wd,
  output logic [DW-1:0] o_grf_pc
);

  localparam int            WW    = $clog2(MAX_WAIT + 1);
  localparam logic [WW-1:0] C_MAX = WW'(MAX_WAIT);

  state_t                    r_state;
  logic [WW-1:0]             r_wait;
  logic                      r_we;
  logic [AW-1:0]             r_addr;
  logic [DW-1:0]             r_wd;
  logic [DW-1:0]             r_pc;
  src_t                      r_src;

  logic                      w_full;
  logic                      w_empty;
  logic [AW-1:0]             w_head_addr;
  logic [DW-1:0]             w_head_wd;
  logic [DW-1:0]             w_head_pc;
  logic [DEPTH-1:0]          w_vld;
  logic [DEPTH-1:0][AW-1:0]  w_ent_addr;
  logic                      w_pipe_eff;
  logic                      w_enq;
  logic                      w_pop;
  logic                      w_grant_pipe;
  logic [WW-1:0]             w_wait_nxt;
  logic                      w_busy1;
  logic                      w_busy2;

  assign w_pipe_eff  = i_pipe_we && (i_pipe_addr != '0);
  assign o_aux_ready = !w_full;
  // Writes to $0 are accepted from the source but never queued.
  assign w_enq       = i_aux_valid && !w_full && (i_aux_addr != '0);

  grf_wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .i_push      (w_enq),
    .i_pop       (w_pop),
    .i_addr      (i_aux_addr),
    .i_wd        (i_aux_wd),
    .i_pc        (i_aux_pc),
    .o_full      (w_full),
    .o_empty     (w_empty),
    .o_head_addr (w_head_addr),
    .o_head_wd   (w_head_wd),
    .o_head_pc   (w_head_pc),
    .o_vld       (w_vld),
    .o_ent_addr  (w_ent_addr)
  );

  always_comb begin
    w_grant_pipe = 1'b0;
    w_pop        = 1'b0;
    if (r_state == ST_FORCE) begin
      w_pop = !w_empty;
    end else if (w_pipe_eff) begin
      w_grant_pipe = 1'b1;
    end else begin
      w_pop = !w_empty;
    end
    w_wait_nxt = (!w_empty && !w_pop) ? r_wait + 1'b1 : '0;
  end

  always_comb begin
    w_busy1 = 1'b0;
    w_busy2 = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (w_vld[i] && (w_ent_addr[i] == i_pend_q1)) w_busy1 = 1'b1;
      if (w_vld[i] && (w_ent_addr[i] == i_pend_q2)) w_busy2 = 1'b1;
    end
  end

  assign o_pend_busy1 = w_busy1 && (i_pend_q1 != '0);
  assign o_pend_busy2 = w_busy2 && (i_pend_q2 != '0);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= ST_NORMAL;
      r_wait  <= '0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wd    <= '0;
      r_pc    <= '0;
      r_src   <= SRC_PIPE;
    end else begin
      r_state <= (w_wait_nxt == C_MAX) ? ST_FORCE : ST_NORMAL;
      r_wait  <= w_wait_nxt;
      if (w_grant_pipe) begin
        r_we   <= 1'b1;
        r_addr <= i_pipe_addr;
        r_wd   <= i_pipe_wd;
        r_pc   <= i_pipe_pc;
        r_src  <= SRC_PIPE;
      end else if (w_pop) begin
        r_we   <= 1'b1;
        r_addr <= w_head_addr;
        r_wd   <= w_head_wd;
        r_pc   <= w_head_pc;
        r_src  <= SRC_AUX;
      end else begin
        r_we   <= 1'b0;
      end
    end
  end

  assign o_pipe_stall = (r_state == ST_FORCE);
  assign o_grf_we     = r_we;
  assign o_grf_addr   = r_addr;
  assign o_grf_wd     = r_wd;
  assign o_grf_pc     = r_pc;

`ifdef GRF_WB_TRACE_EN
  always_ff @(posedge clk) begin
    if (r_we) begin
      $display("%d@%h: $%d <= %h%s", $time, r_pc, r_addr, r_wd,
               (r_src == SRC_PIPE) ? TAG_PIPE : TAG_AUX);
    end
  end
`endif

endmodule
`default_nettype wire

// File: doc/grf_wb_arbiter.md
Name: grf_wb_arbiter

Overview:
Write-port arbiter and sequencer for the single-write-port GRF. It shares the one GRF write port between two requesters:
- the in-order pipeline W stage (priority requester);
- a long-latency result source (MDU/aux), valid/ready handshake, buffered in a small FIFO.
It also reports pending aux writes to the hazard unit and forces a pipeline stall when an aux result has waited too long.

Parameters:
DEPTH, 2, aux FIFO entries (power of 2, >=2)
MAX_WAIT, 4, cycles a non-empty FIFO head may be denied before forcing a stall (>=1)

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-low; clears all state when 0 at posedge clk
pipe_we  in  1  W-stage write enable
pipe_addr  in  5  W-stage destination register
pipe_wd  in  32  W-stage write data
pipe_pc  in  32  W-stage PC (trace only)
pipe_stall  out  1  1 = W-stage write not taken this cycle; pipeline must hold
aux_valid  in  1  aux result offered
aux_ready  out  1  FIFO can accept
aux_addr  in  5  aux destination register
aux_wd  in  32  aux data
aux_pc  in  32  aux PC
pend_q1  in  5  hazard query address 1
pend_q2  in  5  hazard query address 2
pend_busy1  out  1  pend_q1 matches a valid FIFO entry
pend_busy2  out  1  pend_q2 matches a valid FIFO entry
grf_we  out  1  registered GRF write enable
grf_addr  out  5  registered GRF write address
grf_wd  out  32  registered GRF write data
grf_pc  out  32  registered PC of granted write

Behaviour:
- Reset (reset==0 at posedge):
  - FIFO emptied, count=0, wait counter=0, state=NORMAL.
  - grf_we=0, grf_addr=0, grf_wd=0, grf_pc=0.
  - Reset mid-operation discards queued aux entries and drops any in-flight grant.
- Effective pipe write: pipe_we && pipe_addr!=0.
- aux_ready: registered-count based, = (count<DEPTH). Enqueue on aux_valid&&aux_ready.
  - When full, no enqueue even if a pop occurs that cycle.
  - aux_addr==0 is accepted and discarded (never enqueued).
- A newly enqueued entry is not poppable in its enqueue cycle.
- FSM states: NORMAL, FORCE.
- NORMAL:
  - pipe_stall=0.
  - Effective pipe write -> grant pipe.
  - Else FIFO non-empty -> grant head and pop.
  - Else no grant.
- Wait counter:
  - Increments each cycle the FIFO is non-empty and the head is not popped.
  - Clears on pop or when empty.
  - When the counter reaches MAX_WAIT (at the posedge), next state = FORCE.
- FORCE (exactly one cycle):
  - pipe_stall=1 (Moore output). W-stage input is ignored and must be re-presented.
  - Grant head, pop, clear counter, next state = NORMAL.
- Grant timing: the granted write appears on grf_* at the next posedge (1-cycle latency). No grant -> grf_we=0; other grf_* hold previous values.
- Pending-write lookup:
  - pend_busyN is combinational over valid FIFO entries only; the entry being enqueued this cycle is excluded.
  - Query address 0 always gives busy=0.
- Ordering: the arbiter never reorders against the pipe. The hazard unit must use pend_busy to stall any instruction that reads or writes a pending register.
- Simultaneous cases:
  - Pipe write plus FIFO non-empty: pipe wins and the counter increments.
  - Enqueue and pop in the same cycle: count unchanged.

Optional Feature:
GRF_WB_TRACE_EN
- Defined: on each cycle grf_we is registered 1, $display("%d@%h: $%d <= %h", $time, pc, addr, data), followed by a source tag " P" or " A".
- Not defined: no display statements; behaviour otherwise identical.

Decomposition:
- Shared package/header: register-address width (5), data width (32), FSM state encodings, source tag constants.
- One natural sub-module, grf_wb_fifo: DEPTH-entry synchronous FIFO.
  - Carries addr/wd/pc and exposes per-entry valid and addr for the pending lookup.
  - Keeps count, pointers and wrap-around.

Test Plan:
- Reset held low 2 cycles with aux_valid=1 and pipe_we=1 -> grf_we=0, aux_ready=1 after release, count=0, pend_busy1=0.
- Pipe only, addr=5, wd=0xDEADBEEF -> next cycle grf_we=1, grf_addr=5, grf_wd=0xDEADBEEF, pipe_stall=0.
- Aux enqueue addr=8, wd=0x12 while pipe idle -> pend_busy1=1 for pend_q1=8 one cycle after enqueue; head pops the following cycle; grf_addr=8 one cycle later; pend_busy1 returns to 0.
- DEPTH=2, two aux enqueues, third aux_valid held -> aux_ready=0 while count=2; entry addr=0 offered when not full -> accepted, never written.
- Pipe writes every cycle with one aux entry queued, MAX_WAIT=4 -> after 4 denied cycles pipe_stall=1 for exactly 1 cycle, aux entry written, the held pipe write is written the cycle after.
- Reset asserted while FIFO holds 2 entries -> FIFO flushed, no aux write ever appears on grf_*.
